// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 key-scan reader: read-keys command,
// frame state encoding and the raw-frame to key-vector mapping.
package tm1638_pkg;

    localparam logic [7:0] TM1638_CMD_READ_KEYS = 8'h42;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        WAIT  = 3'd3,
        READ  = 3'd4,
        HOLD  = 3'd5
    } tm1638_state_t;

    // Byte i bit0 is button S(i+1); byte i bit4 is button S(i+5).
    function automatic logic [7:0] tm1638_key_map(input logic [31:0] raw);
        logic [7:0] k;
        k = 8'h00;
        for (int i = 0; i < 4; i++) begin
            k[i]     = raw[8*i];
            k[i + 4] = raw[8*i + 4];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Serial-clock bit timer: counts 2*CLK_DIV clk cycles per bit while enabled.
// The first CLK_DIV cycles of a bit are the sclk low phase, the rest the high
// phase. high_next tells the top which phase the following cycle is in, so
// sclk can be driven from a register without a cycle of lag.
module tm1638_bit_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_low_start,
    output logic phase_high_end,
    output logic high_next
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;

    // Next count: wraps once per bit, parked at zero while disabled.
    always_comb begin
        cnt_next_s = '0;
        if (!en) begin
            cnt_next_s = '0;
        end else if (cnt_r == LAST) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
    end

    // Half-period counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign phase_low_start = en && (cnt_r == '0);
    assign phase_high_end  = en && (cnt_r == LAST);
    assign high_next       = (cnt_next_s >= HALF);

endmodule

// File: rtl/tm1638_key_scan.sv
// TM1638 read-keys frame engine: on start, sends 0x42 LSB first, waits TWAIT
// cycles, clocks in 32 bits LSB first and decodes the eight buttons.
// Optional feature macro: TM1638_KEY_DEBOUNCE_EN (two matching scans needed
// before keys changes).
module tm1638_key_scan
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV = 25,
    parameter int TWAIT   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [7:0] keys,
    output logic       keys_valid,
    output logic       stb,
    output logic       sclk,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in
);

    localparam int CYC_MAX = (TWAIT > CLK_DIV) ? TWAIT : CLK_DIV;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    tm1638_state_t    state_r;
    tm1638_state_t    state_next_s;
    logic [5:0]       bit_cnt_r;
    logic [CYC_W-1:0] cyc_cnt_r;
    logic [31:0]      shift_r;
    logic             done_r;
    logic             timer_en_s;
    logic             phase_low_start_s;
    logic             phase_high_end_s;
    logic             high_next_s;
    logic             stb_d_s;
    logic             busy_d_s;
    logic             sclk_d_s;
    logic             dio_out_d_s;
    logic             dio_oe_d_s;
    logic [7:0]       raw_s;
    logic [7:0]       keys_next_s;

    assign timer_en_s = (state_r == CMD) || (state_r == READ);

    tm1638_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk             (clk),
        .rst             (rst),
        .en              (timer_en_s),
        .phase_low_start (phase_low_start_s),
        .phase_high_end  (phase_high_end_s),
        .high_next       (high_next_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; bit_cnt counts bits begun, so it reads 8/32 at the
    // end of the last bit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = SETUP;
                else       state_next_s = IDLE;
            end
            SETUP: begin
                if (cyc_cnt_r == CYC_W'(CLK_DIV - 1)) state_next_s = CMD;
                else                                  state_next_s = SETUP;
            end
            CMD: begin
                if (phase_high_end_s && (bit_cnt_r == 6'd8)) state_next_s = WAIT;
                else                                         state_next_s = CMD;
            end
            WAIT: begin
                if (cyc_cnt_r == CYC_W'(TWAIT - 1)) state_next_s = READ;
                else                                state_next_s = WAIT;
            end
            READ: begin
                if (phase_high_end_s && (bit_cnt_r == 6'd32)) state_next_s = HOLD;
                else                                          state_next_s = READ;
            end
            HOLD: begin
                if (cyc_cnt_r == CYC_W'(CLK_DIV - 1)) state_next_s = IDLE;
                else                                  state_next_s = HOLD;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // pin registers line up with the state they belong to.
    always_comb begin
        stb_d_s     = (state_next_s == IDLE);
        busy_d_s    = (state_next_s != IDLE);
        dio_oe_d_s  = (state_next_s == CMD);
        sclk_d_s    = 1'b1;
        dio_out_d_s = 1'b0;
        case (state_next_s)
            CMD, READ: sclk_d_s = high_next_s;
            default:   sclk_d_s = 1'b1;
        endcase
        if (state_next_s == CMD) begin
            if ((state_r != CMD) || phase_high_end_s) begin
                dio_out_d_s = TM1638_CMD_READ_KEYS[bit_cnt_r[2:0]];
            end else begin
                dio_out_d_s = dio_out;
            end
        end else begin
            dio_out_d_s = 1'b0;
        end
    end

    // Pin and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb     <= 1'b1;
            sclk    <= 1'b1;
            dio_out <= 1'b0;
            dio_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            stb     <= stb_d_s;
            sclk    <= sclk_d_s;
            dio_out <= dio_out_d_s;
            dio_oe  <= dio_oe_d_s;
            busy    <= busy_d_s;
        end
    end

    // Bit and cycle counters, both cleared on every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= 6'd0;
            cyc_cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            bit_cnt_r <= 6'd0;
            cyc_cnt_r <= '0;
        end else begin
            if (phase_low_start_s) bit_cnt_r <= bit_cnt_r + 6'd1;
            else                   bit_cnt_r <= bit_cnt_r;
            if ((state_r == SETUP) || (state_r == WAIT) || (state_r == HOLD)) begin
                cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
            end else begin
                cyc_cnt_r <= '0;
            end
        end
    end

    // Read shift register: sample dio_in at the end of each sclk high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= 32'h0000_0000;
        end else if ((state_r == READ) && phase_high_end_s) begin
            shift_r <= {dio_in, shift_r[31:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign raw_s = tm1638_key_map(shift_r);

`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0] prev_raw_r;

    // Previous raw scan, compared against the new one before keys may move.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw_r <= 8'h00;
        end else if (done_r) begin
            prev_raw_r <= raw_s;
        end else begin
            prev_raw_r <= prev_raw_r;
        end
    end

    assign keys_next_s = (raw_s == prev_raw_r) ? raw_s : keys;
`else
    assign keys_next_s = raw_s;
`endif

    // Frame completion: keys and keys_valid land one edge after stb rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r     <= 1'b0;
            keys       <= 8'h00;
            keys_valid <= 1'b0;
        end else begin
            done_r     <= (state_r == HOLD) && (state_next_s == IDLE);
            keys_valid <= done_r;
            if (done_r) keys <= keys_next_s;
            else        keys <= keys;
        end
    end

endmodule

// File: tb/tb_tm1638_key_scan.sv
// Self-checking bench for tm1638_key_scan with CLK_DIV=2, TWAIT=4.
// A TM1638 stub answers read frames on dio_in; expected keys come from a
// byte/bit arithmetic model of the key map (and of debounce when enabled).
module tb_tm1638_key_scan;

    localparam int CD      = 2;
    localparam int TW      = 4;
    localparam int STB_LOW = 82 * CD + TW;   // 168
    localparam int PER     = STB_LOW + 1;    // 169

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       dio_in = 1'b0;
    logic       busy;
    logic [7:0] keys;
    logic       keys_valid;
    logic       stb;
    logic       sclk;
    logic       dio_out;
    logic       dio_oe;

    tm1638_key_scan #(.CLK_DIV(CD), .TWAIT(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .keys       (keys),
        .keys_valid (keys_valid),
        .stb        (stb),
        .sclk       (sclk),
        .dio_out    (dio_out),
        .dio_oe     (dio_oe),
        .dio_in     (dio_in)
    );

    always #5 clk = ~clk;

    int         n_assert   = 0;
    int         n_fail     = 0;
    logic [31:0] frame_word = 32'h0;
    int         rd_idx     = 0;
    int         rd_rise    = 0;
    int         oe_rise    = 0;
    logic [7:0] cmd_cap    = 8'h00;
    logic [7:0] keys_m     = 8'h00;
`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0] prev_m     = 8'h00;
`endif

    // TM1638 stub: presents the next frame bit shortly after each read-phase sclk fall.
    initial begin
        forever begin
            @(negedge sclk);
            #1;
            if (dio_oe === 1'b1) begin
                rd_idx = 0;
            end else if (stb === 1'b0) begin
                dio_in = frame_word[rd_idx[4:0]];
                rd_idx++;
            end
        end
    end

    // Capture command bits and count read clocks on sclk rising edges.
    initial begin
        forever begin
            @(posedge sclk);
            if (dio_oe === 1'b1) begin
                if (oe_rise < 8) cmd_cap[oe_rise] = dio_out;
                oe_rise++;
            end else if (stb === 1'b0) begin
                rd_rise++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_keys(input logic [31:0] fw);
        logic [7:0] k;
        k = 8'h00;
        for (int b = 0; b < 4; b++) begin
            k[b]     = ((fw >> (8 * b)) & 32'h1) != 32'h0;
            k[b + 4] = ((fw >> (8 * b + 4)) & 32'h1) != 32'h0;
        end
        return k;
    endfunction

    task automatic model_scan(input logic [31:0] fw);
        logic [7:0] raw;
        raw = ref_keys(fw);
`ifdef TM1638_KEY_DEBOUNCE_EN
        if (raw == prev_m) keys_m = raw;
        prev_m = raw;
`else
        keys_m = raw;
`endif
    endtask

    task automatic model_reset();
        keys_m = 8'h00;
`ifdef TM1638_KEY_DEBOUNCE_EN
        prev_m = 8'h00;
`endif
    endtask

    // One complete frame; extra_at >= 0 pulses start again at that cycle.
    task automatic scan(input logic [31:0] fw, input int extra_at, input string tag);
        int stb_low_n = 0;
        int busy_n    = 0;
        int busy_fall = -1;
        int kv_n      = 0;
        int kv_cyc    = -1;
        frame_word = fw;
        rd_rise    = 0;
        oe_rise    = 0;
        cmd_cap    = 8'h00;
        model_scan(fw);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc <= STB_LOW + 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (stb === 1'b0) stb_low_n++;
            if (busy === 1'b1) busy_n++;
            else if (busy_fall < 0) busy_fall = cyc;
            if (keys_valid === 1'b1) begin
                kv_n++;
                kv_cyc = cyc;
                chk({tag, " keys"}, {24'h0, keys}, {24'h0, keys_m});
            end
            if (cyc == extra_at) start = 1'b1;
            else                 start = 1'b0;
        end
        chk({tag, " stb_low_cycles"}, stb_low_n, STB_LOW);
        chk({tag, " busy_cycles"}, busy_n, STB_LOW);
        chk({tag, " busy_fall_cycle"}, busy_fall, STB_LOW);
        chk({tag, " keys_valid_count"}, kv_n, 1);
        chk({tag, " keys_valid_cycle"}, kv_cyc, PER);
        chk({tag, " cmd_byte"}, {24'h0, cmd_cap}, 32'h42);
        chk({tag, " cmd_clocks"}, oe_rise, 8);
        chk({tag, " read_clocks_oe_low"}, rd_rise, 32);
        chk({tag, " keys_after"}, {24'h0, keys}, {24'h0, keys_m});
    endtask

    initial begin
        int kv_n;
        logic [31:0] fw;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset stb", stb, 1);
        chk("reset sclk", sclk, 1);
        chk("reset dio_out", dio_out, 0);
        chk("reset dio_oe", dio_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset keys", keys, 0);
        chk("reset keys_valid", keys_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset at cycle 100 of a frame aborts it.
        frame_word = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort mid-frame stb low", stb, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort stb", stb, 1);
        chk("abort sclk", sclk, 1);
        chk("abort dio_oe", dio_oe, 0);
        chk("abort busy", busy, 0);
        chk("abort keys", keys, 0);
        chk("abort keys_valid", keys_valid, 0);
        rst = 1'b0;
        model_reset();
        kv_n = 0;
        repeat (200) begin
            @(negedge clk);
            if (keys_valid === 1'b1) kv_n++;
        end
        chk("abort no keys_valid", kv_n, 0);
        chk("abort stays idle", stb, 1);

        // Directed frame: bytes 01,00,10,00.
        scan(32'h0010_0001, -1, "directed");

        // Start pulsed while busy is ignored.
        scan($urandom, 50, "busy_start");

        // Random frames.
        for (int i = 0; i < 6; i++) begin
            scan($urandom, -1, "random");
        end

        // Debounce-oriented sequences (also plain loads without debounce).
        scan(32'hFFFF_FFFF, -1, "seq_ff");
        scan(32'h0000_0000, -1, "seq_00a");
        scan(32'h0000_0000, -1, "seq_00b");
        scan(32'h1111_1111, -1, "seq_11a");
        scan(32'h1111_1111, -1, "seq_11b");

        // start held high: three back-to-back frames.
        fw = $urandom;
        frame_word = fw;
        kv_n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc <= 3 * PER + 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 2 * PER) start = 1'b0;
            if (keys_valid === 1'b1) begin
                kv_n++;
                model_scan(fw);
                chk("held keys", {24'h0, keys}, {24'h0, keys_m});
                chk("held keys_valid_cycle", cyc, kv_n * PER);
            end
            if ((cyc == PER - 1) || (cyc == 2 * PER - 1)) chk("held stb high gap", stb, 1);
            if ((cyc == PER) || (cyc == 2 * PER)) chk("held restart stb low", stb, 0);
        end
        chk("held keys_valid_count", kv_n, 3);
        chk("held final idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
